// File: rtl/vending_pkg.sv
//----------------------------------------------------------------------
// vending_pkg: coin encodings, denominations and dispenser FSM states.
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

package vending_pkg;

  localparam int c_amt_w = 5;

  localparam logic [1:0] c_coin_1  = 2'd0;
  localparam logic [1:0] c_coin_2  = 2'd1;
  localparam logic [1:0] c_coin_5  = 2'd2;
  localparam logic [1:0] c_coin_10 = 2'd3;

  localparam logic [c_amt_w-1:0] c_denom_1  = 5'd1;
  localparam logic [c_amt_w-1:0] c_denom_2  = 5'd2;
  localparam logic [c_amt_w-1:0] c_denom_5  = 5'd5;
  localparam logic [c_amt_w-1:0] c_denom_10 = 5'd10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4
  } disp_state_t;

  function automatic logic [c_amt_w-1:0] coin_value(input logic [1:0] i_type);
    logic [c_amt_w-1:0] w_val;
    case (i_type)
      c_coin_1:  w_val = c_denom_1;
      c_coin_2:  w_val = c_denom_2;
      c_coin_5:  w_val = c_denom_5;
      default:   w_val = c_denom_10;
    endcase
    return w_val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/change_dispenser_if.sv
//----------------------------------------------------------------------
// change_dispenser_if: request, hopper handshake and status bundle.
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

interface change_dispenser_if;
  import vending_pkg::*;

  logic [c_amt_w-1:0] change_amount;
  logic               change_valid;
  logic               coin_ack;
  logic               coin_req;
  logic [1:0]         coin_type;
  logic               busy;
  logic               done;
  logic               error;
  logic [c_amt_w-1:0] remaining;
`ifdef CHANGE_INVENTORY_EN
  logic               refill;
`endif

  modport slave (
`ifdef CHANGE_INVENTORY_EN
    input  refill,
`endif
    input  change_amount, change_valid, coin_ack,
    output coin_req, coin_type, busy, done, error, remaining
  );

  modport master (
`ifdef CHANGE_INVENTORY_EN
    output refill,
`endif
    output change_amount, change_valid, coin_ack,
    input  coin_req, coin_type, busy, done, error, remaining
  );

endinterface

`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
//----------------------------------------------------------------------
// change_coin_select: greedy picker, largest in-stock coin <= remaining.
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

module change_coin_select
  import vending_pkg::*;
(
  input  wire logic [c_amt_w-1:0] i_remaining,
  input  wire logic [3:0]         i_stock_ok,
  output logic      [1:0]         o_coin_type,
  output logic                    o_found
);

  // Ascending priority: a later match overrides, so the largest wins.
  always_comb begin
    o_coin_type = c_coin_1;
    o_found     = 1'b0;
    if (i_stock_ok[0] && (i_remaining >= c_denom_1)) begin
      o_coin_type = c_coin_1;
      o_found     = 1'b1;
    end
    if (i_stock_ok[1] && (i_remaining >= c_denom_2)) begin
      o_coin_type = c_coin_2;
      o_found     = 1'b1;
    end
    if (i_stock_ok[2] && (i_remaining >= c_denom_5)) begin
      o_coin_type = c_coin_5;
      o_found     = 1'b1;
    end
    if (i_stock_ok[3] && (i_remaining >= c_denom_10)) begin
      o_coin_type = c_coin_10;
      o_found     = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
//----------------------------------------------------------------------
// change_dispenser: greedy coin dispenser driving a req/ack hopper.
// Optional per-denomination stock tracking: CHANGE_INVENTORY_EN.
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

module change_dispenser
  import vending_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int INIT_STOCK  = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  change_dispenser_if.slave bus
);

  localparam logic [7:0] c_tmo_last   = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] c_init_stock = 4'(INIT_STOCK);

  disp_state_t        r_state;
  logic [c_amt_w-1:0] r_remaining;
  logic [1:0]         r_coin_type;
  logic               r_coin_req;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [7:0]         r_tmo;

  logic [3:0]         w_stock_ok;
  logic [1:0]         w_sel_type;
  logic               w_found;
  logic               w_take;

  assign w_take = (r_state == ST_DISPENSE) && bus.coin_ack;

`ifdef CHANGE_INVENTORY_EN
  logic [3:0] r_stock [4];
  logic       w_refill_go;

  assign w_refill_go = (r_state == ST_IDLE) && bus.refill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_stock[k] <= c_init_stock;
    end else if (w_refill_go) begin
      for (int k = 0; k < 4; k++) r_stock[k] <= c_init_stock;
    end else if (w_take) begin
      r_stock[r_coin_type] <= r_stock[r_coin_type] - 4'd1;
    end
  end

  always_comb begin
    w_stock_ok = 4'b0000;
    for (int k = 0; k < 4; k++) w_stock_ok[k] = (r_stock[k] != 4'd0);
  end
`else
  assign w_stock_ok = 4'b1111;
`endif

  change_coin_select u_select (
    .i_remaining (r_remaining),
    .i_stock_ok  (w_stock_ok),
    .o_coin_type (w_sel_type),
    .o_found     (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_coin_type <= c_coin_1;
      r_coin_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_tmo       <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.change_valid) begin
            r_remaining <= bus.change_amount;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (!w_found) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_coin_type <= w_sel_type;
            r_tmo       <= 8'd0;
            r_coin_req  <= 1'b1;
            r_state     <= ST_DISPENSE;
          end
        end
        // An ack in the final allowed cycle still counts as on time.
        ST_DISPENSE: begin
          if (bus.coin_ack) begin
            r_remaining <= r_remaining - coin_value(r_coin_type);
            r_coin_req  <= 1'b0;
            r_state     <= ST_GAP;
          end else if (r_tmo == c_tmo_last) begin
            r_coin_req <= 1'b0;
            r_error    <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        ST_GAP: begin
          r_state <= ST_SELECT;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_coin_req <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.coin_req  = r_coin_req;
  assign bus.coin_type = r_coin_type;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.remaining = r_remaining;

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the change calculator. Accepts a 5-bit change amount with a one-cycle valid pulse, breaks it greedily into coins of 10, 5, 2 and 1 units, and drives a coin hopper one coin at a time over a req/ack handshake. Reports completion, the undispensed remainder, and faults (hopper timeout, insufficient stock).

## Interface
Parameters:
- ACK_TIMEOUT, 255: maximum cycles to wait for `coin_ack` per coin before faulting (8-bit counter, legal range 1..255).
- INIT_STOCK, 8: initial and reset coin count per denomination. Used only with `CHANGE_INVENTORY_EN`. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- change_amount  in  5  amount to return, 0..31 units.
- change_valid  in  1  one-cycle strobe; `change_amount` is sampled on it. Ignored while `busy`.
- coin_ack  in  1  hopper acknowledges that the current coin has been ejected.
- coin_req  out  1  request the hopper to eject one coin of type `coin_type`.
- coin_type  out  2  coin encoding: 0 = 1, 1 = 2, 2 = 5, 3 = 10 units.
- busy  out  1  high from the cycle after acceptance until `done`.
- done  out  1  one-cycle pulse at the end of every accepted request, whether it succeeded or faulted.
- error  out  1  set together with a faulting `done`; held until the next accepted request.
- remaining  out  5  undispensed amount; counts down per acked coin.
- refill  in  1  restores all stock counters to INIT_STOCK. Present only with `CHANGE_INVENTORY_EN`; ignored while `busy`.

## Operation
- States: IDLE, SELECT, DISPENSE, GAP, DONE.
- IDLE: on `change_valid`, latch `change_amount` into `remaining`, clear `error`, and go to SELECT.
- SELECT: pick the largest denomination that is less than or equal to `remaining` and has stock available. Without inventory, stock is always available.
  - If `remaining` = 0, go to DONE.
  - If no denomination qualifies, set `error` and go to DONE.
  - Otherwise, register `coin_type`, clear the timeout counter, and go to DISPENSE.
- DISPENSE: `coin_req` is high and `coin_type` is stable.
  - When `coin_ack` is sampled high, subtract the denomination from `remaining`, decrement that stock counter, and go to GAP.
  - When the timeout counter reaches ACK_TIMEOUT without an ack, set `error` and go to DONE. `remaining` is left unchanged.
- GAP: `coin_req` is low for exactly one cycle, then go to SELECT. This gives the hopper a mandatory deassertion between coins.
- DONE: `done` is high for one cycle, then go to IDLE.
- Arithmetic: all values are unsigned 5-bit. The subtraction cannot underflow because of the selection rule.
- An ack outside DISPENSE is ignored.

## Timing
- Reset values: `coin_req` 0, `coin_type` 0, `busy` 0, `done` 0, `error` 0, `remaining` 0, state IDLE, stock counters INIT_STOCK, timeout counter 0.
- `change_valid` in cycle N gives SELECT in cycle N+1 and the first `coin_req` high in cycle N+2.
- Per coin, with the ack arriving in the first DISPENSE cycle: 3 cycles (SELECT, DISPENSE, GAP).
- An amount of 0 produces a `done` pulse 2 cycles after `change_valid`, with no coin request.
- `busy` is high in SELECT, DISPENSE, GAP and DONE.
- A `change_valid` that arrives in the DONE cycle is ignored. It is accepted only in IDLE.
- Reset asserted mid-operation drops `coin_req` immediately. No partial coin is accounted for.

## Configuration
- `CHANGE_INVENTORY_EN` defined:
  - One 4-bit stock counter per denomination.
  - A denomination with zero stock is skipped in SELECT.
  - The `refill` port exists.
  - If no denomination qualifies while `remaining` > 0, `error` is set.
- `CHANGE_INVENTORY_EN` undefined:
  - No counters and no `refill` port.
  - Stock is unlimited, so the only possible fault is a timeout.

## Structure
- Shared package `vending_pkg`: coin type encoding constants, denomination values (1/2/5/10), the dispenser state enum, and the 5-bit amount width constant.
- One sub-module, `change_coin_select`: combinational greedy picker.
  - Inputs: `remaining` and a 4-bit stock-available mask.
  - Outputs: `coin_type` and a `found` flag.
- Top level: FSM, timeout counter, and stock counters.

## Test plan
- Amount 18, ack one cycle after each req:
  - Coins issued in order 10, 5, 2, 1 (coin types 3, 2, 1, 0).
  - `remaining` goes 18→8→3→1→0.
  - `done` pulses with `error` = 0.
- Amount 0: `done` pulses 2 cycles after `change_valid`, `coin_req` never rises, `error` = 0.
- Hopper never acks, amount 5, ACK_TIMEOUT = 4:
  - `coin_req` is high for 4 cycles, then `done` and `error` assert.
  - `remaining` = 5 and `coin_req` drops.
- Inventory build, INIT_STOCK = 1, amounts 10 then 10:
  - The first request dispenses a single 10.
  - The second request dispenses 5, 2, 1, then faults with `remaining` = 2 and `error` = 1.
  - After `refill`, a third request for 10 succeeds with a single 10.
- Reset asserted during DISPENSE of amount 12:
  - `coin_req`, `busy` and `remaining` go to 0 asynchronously.
  - A new request for 3 then dispenses 2 and 1 correctly.
- `change_valid` pulsed while `busy`: the pulse is ignored, and the original amount completes unchanged.
